hrav_scan_gate: RTL and testbench

HRAV_SCAN_GATE -- requirements
Module: hrav_scan_gate

---
 rtl/hrav_scan_gate.sv | 188 ++++++++++++++++++
 tb/tb_hrav_scan_gate.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hrav_scan_gate.sv
// Signature scan gate: passes an AXI-Stream unmodified through a 2-entry slice while
// counting scanned packets and packets containing a 32-bit signature in any full lane.
// Latency: 1 cycle input->output. Backpressure: registered s_axis_tready; low only while the skid entry is full.
//
// Ports:
//   ACLK / ARESETN          clock, synchronous active-low reset
//   ctrl_en_scn             scan enable, sampled only on the first beat of a packet
//   scn_sig                 32-bit signature compared against every 32-bit lane
//   cnt_clr                 one-cycle pulse that zeroes pkt_cnt and match_cnt
//   s_axis_*                input stream (tdata/tkeep/tvalid/tlast/tready)
//   m_axis_*                output stream, beats identical to the input stream
//   pkt_cnt / match_cnt     saturating counts of scanned / matched packets
//   match_pulse             one-cycle alert after each matched packet is counted
module hrav_scan_gate #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    ctrl_en_scn,
  input  logic [31:0]             scn_sig,
  input  logic                    cnt_clr,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic [31:0]             pkt_cnt,
  output logic [31:0]             match_cnt,
  output logic                    match_pulse
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int NL = DATA_WIDTH / 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_BYPASS = 2'd2;

  logic                  out_vld_q,  out_vld_d;
  logic [DATA_WIDTH-1:0] out_dat_q,  out_dat_d;
  logic [KW-1:0]         out_keep_q, out_keep_d;
  logic                  out_last_q, out_last_d;
  logic                  skid_vld_q,  skid_vld_d;
  logic [DATA_WIDTH-1:0] skid_dat_q,  skid_dat_d;
  logic [KW-1:0]         skid_keep_q, skid_keep_d;
  logic                  skid_last_q, skid_last_d;
  logic                  rdy_q, rdy_d;
  logic [1:0]            state_q, state_d;
  logic                  flag_q, flag_d;
  logic [31:0]           pkt_cnt_q, pkt_cnt_d;
  logic [31:0]           match_cnt_q, match_cnt_d;
  logic                  pulse_q, pulse_d;

  logic in_hs;
  logic lane_hit;
  logic pkt_start;
  logic scanning;
  logic flag_eff;

  // rdy_q mirrors "skid empty", so an accepted beat never finds the skid occupied.
  assign in_hs = s_axis_tvalid & rdy_q;

  always_comb begin
    lane_hit = 1'b0;
    for (int i = 0; i < NL; i++) begin
      if (s_axis_tdata[32*i +: 32] == scn_sig && s_axis_tkeep[4*i +: 4] == 4'hF) begin
        lane_hit = 1'b1;
      end
    end
  end

  // Register slice: output register refills from the skid first, then from the input.
  always_comb begin
    out_vld_d   = out_vld_q;
    out_dat_d   = out_dat_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    skid_vld_d  = skid_vld_q;
    skid_dat_d  = skid_dat_q;
    skid_keep_d = skid_keep_q;
    skid_last_d = skid_last_q;
    if (!out_vld_q || m_axis_tready) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_dat_d  = skid_dat_q;
        out_keep_d = skid_keep_q;
        out_last_d = skid_last_q;
        skid_vld_d = 1'b0;
      end else if (in_hs) begin
        out_vld_d  = 1'b1;
        out_dat_d  = s_axis_tdata;
        out_keep_d = s_axis_tkeep;
        out_last_d = s_axis_tlast;
      end else begin
        out_vld_d  = 1'b0;
      end
    end else if (in_hs) begin
      skid_vld_d  = 1'b1;
      skid_dat_d  = s_axis_tdata;
      skid_keep_d = s_axis_tkeep;
      skid_last_d = s_axis_tlast;
    end
    rdy_d = ~skid_vld_d;
  end

  // Packet FSM and counters, all advanced on input handshakes.
  always_comb begin
    pkt_start   = (state_q == ST_IDLE);
    scanning    = pkt_start ? ctrl_en_scn : (state_q == ST_SCAN);
    // The sticky flag restarts on the first beat, so a stale flag never leaks across packets.
    flag_eff    = (pkt_start ? 1'b0 : flag_q) | lane_hit;
    state_d     = state_q;
    flag_d      = flag_q;
    pkt_cnt_d   = pkt_cnt_q;
    match_cnt_d = match_cnt_q;
    pulse_d     = 1'b0;
    if (in_hs) begin
      if (s_axis_tlast) begin
        state_d = ST_IDLE;
        flag_d  = 1'b0;
        if (scanning) begin
          if (pkt_cnt_q != 32'hFFFF_FFFF) pkt_cnt_d = pkt_cnt_q + 32'd1;
          if (flag_eff) begin
            pulse_d = 1'b1;
            if (match_cnt_q != 32'hFFFF_FFFF) match_cnt_d = match_cnt_q + 32'd1;
          end
        end
      end else begin
        if (pkt_start) state_d = ctrl_en_scn ? ST_SCAN : ST_BYPASS;
        flag_d = scanning & flag_eff;
      end
    end
    // Clearing overrides a coincident increment; the alert pulse is left intact.
    if (cnt_clr) begin
      pkt_cnt_d   = 32'd0;
      match_cnt_d = 32'd0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      out_vld_q   <= 1'b0;
      out_dat_q   <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_dat_q  <= '0;
      skid_keep_q <= '0;
      skid_last_q <= 1'b0;
      rdy_q       <= 1'b0;
      state_q     <= ST_IDLE;
      flag_q      <= 1'b0;
      pkt_cnt_q   <= 32'd0;
      match_cnt_q <= 32'd0;
      pulse_q     <= 1'b0;
    end else begin
      out_vld_q   <= out_vld_d;
      out_dat_q   <= out_dat_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      skid_vld_q  <= skid_vld_d;
      skid_dat_q  <= skid_dat_d;
      skid_keep_q <= skid_keep_d;
      skid_last_q <= skid_last_d;
      rdy_q       <= rdy_d;
      state_q     <= state_d;
      flag_q      <= flag_d;
      pkt_cnt_q   <= pkt_cnt_d;
      match_cnt_q <= match_cnt_d;
      pulse_q     <= pulse_d;
    end
  end

  assign s_axis_tready = rdy_q;
  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tdata  = out_dat_q;
  assign m_axis_tkeep  = out_keep_q;
  assign m_axis_tlast  = out_last_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign match_cnt     = match_cnt_q;
  assign match_pulse   = pulse_q;

endmodule

// File: tb/tb_hrav_scan_gate.sv
module tb_hrav_scan_gate;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        ctrl_en_scn = 1'b0;
  logic [31:0] scn_sig = 32'hDEADBEEF;
  logic        cnt_clr = 1'b0;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic [31:0] pkt_cnt;
  logic [31:0] match_cnt;
  logic        match_pulse;

  hrav_scan_gate #(.DATA_WIDTH(64)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .ctrl_en_scn(ctrl_en_scn), .scn_sig(scn_sig),
    .cnt_clr(cnt_clr),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .pkt_cnt(pkt_cnt), .match_cnt(match_cnt), .match_pulse(match_pulse)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [31:0] c;
  } beat_t;

  typedef struct packed {
    logic            en;
    logic [2:0]      nb;
    logic [3:0][63:0] d;
    logic [3:0][7:0] k;
    logic [31:0]     e_pkt;
    logic [31:0]     e_match;
    logic [31:0]     e_pul;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  logic        pulse_prev = 1'b0;
  logic [31:0] cyc = 0;
  logic        lat_chk = 1'b1;
  logic        occ_chk = 1'b0;
  logic        rand_rdy = 1'b0;
  int          occ = 0;
  beat_t       exp_q[$];
  logic        hold_vld = 1'b0;
  beat_t       held;
  vec_t        tv[9];

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Output scoreboard: order, content and (when enabled) one-cycle latency.
  always @(negedge ACLK) begin
    if (ARESETN && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", m_axis_tdata, 64'hX);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("out_data", m_axis_tdata, e.d);
        chk("out_keep_last", {m_axis_tkeep, m_axis_tlast}, {e.k, e.l});
        if (lat_chk) chk("latency", cyc - e.c, 64'd1);
      end
    end
  end

  // Output must hold steady while stalled.
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (hold_vld) begin
        chk("stall_hold", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast},
            {1'b1, held.d, held.k, held.l});
      end
      hold_vld = m_axis_tvalid && !m_axis_tready;
      held.d = m_axis_tdata;
      held.k = m_axis_tkeep;
      held.l = m_axis_tlast;
      held.c = cyc;
    end else begin
      hold_vld = 1'b0;
    end
  end

  // Pulse counter; a pulse must never span two cycles.
  always @(negedge ACLK) begin
    if (ARESETN && match_pulse) begin
      pulses++;
      chk("pulse_width", {63'd0, pulse_prev}, 64'd0);
    end
    pulse_prev = match_pulse;
  end

  // Occupancy model: ready is low only when both slice entries hold a beat.
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      occ = 0;
    end else begin
      if (occ_chk) chk("s_tready_vs_occ", {63'd0, s_axis_tready}, {63'd0, (occ < 2)});
      occ = occ + ((s_axis_tvalid && s_axis_tready) ? 1 : 0) - ((m_axis_tvalid && m_axis_tready) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
    if (rand_rdy) m_axis_tready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l, input logic clr);
    bit done;
    done = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    cnt_clr       = clr;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge ACLK);
      if (s_axis_tready) begin
        exp_q.push_back('{d: d, k: k, l: l, c: cyc});
        done = 1;
      end
      tick();
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    cnt_clr       = 1'b0;
  endtask

  task automatic chk_cnt(input string nm, input logic [31:0] p, input logic [31:0] m, input int u);
    repeat (3) tick();
    @(negedge ACLK);
    chk({nm, "_pkt_cnt"}, pkt_cnt, p);
    chk({nm, "_match_cnt"}, match_cnt, m);
    chk({nm, "_pulses"}, pulses, u);
    tick();
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) tick();
    chk("drain_empty", exp_q.size(), 64'd0);
  endtask

  function automatic vec_t mk(input logic en, input logic [2:0] nb,
                              input logic [63:0] d0, d1, d2, d3,
                              input logic [7:0] k0, k1, k2, k3,
                              input int p, m, u);
    vec_t v;
    v.en = en; v.nb = nb;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.k[0] = k0; v.k[1] = k1; v.k[2] = k2; v.k[3] = k3;
    v.e_pkt = p; v.e_match = m; v.e_pul = u;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Cumulative expected pkt_cnt / match_cnt / pulse count after each packet.
    tv[0] = mk(1, 3, 64'h11111111_22222222, 64'hDEADBEEF_00000001, 64'h3, 64'h0,
               8'hFF, 8'hFF, 8'hFF, 8'hFF, 1, 1, 1);
    tv[1] = mk(1, 3, 64'h11111111_22222222, 64'hDEADBEEF_00000001, 64'h3, 64'h0,
               8'hFF, 8'h0F, 8'hFF, 8'hFF, 2, 1, 1);
    tv[2] = mk(0, 1, 64'h00000000_DEADBEEF, 64'h0, 64'h0, 64'h0,
               8'hFF, 8'hFF, 8'hFF, 8'hFF, 2, 1, 1);
    tv[3] = mk(1, 1, 64'h00000000_DEADBEEF, 64'h0, 64'h0, 64'h0,
               8'hFF, 8'hFF, 8'hFF, 8'hFF, 3, 2, 2);
    tv[4] = mk(1, 2, 64'hBEEF0000_0000DEAD, 64'h0, 64'h0, 64'h0,
               8'hFF, 8'hFF, 8'hFF, 8'hFF, 4, 2, 2);
    tv[5] = mk(1, 2, 64'h12345678_DEADBEEF, 64'h0, 64'h0, 64'h0,
               8'hFF, 8'hFF, 8'hFF, 8'hFF, 5, 3, 3);
    tv[6] = mk(1, 1, 64'h00000000_DEADBEEF, 64'h0, 64'h0, 64'h0,
               8'hF0, 8'hFF, 8'hFF, 8'hFF, 6, 3, 3);
    tv[7] = mk(1, 4, 64'h1, 64'h2, 64'h3, 64'hDEADBEEF_00000000,
               8'hFF, 8'hFF, 8'hFF, 8'hFF, 7, 4, 4);
    tv[8] = mk(1, 1, 64'hDEADBEEF_DEADBEEF, 64'h0, 64'h0, 64'h0,
               8'hFF, 8'hFF, 8'hFF, 8'hFF, 8, 5, 5);

    // Reset state.
    repeat (3) tick();
    @(negedge ACLK);
    chk("rst_m_tvalid", m_axis_tvalid, 64'd0);
    chk("rst_s_tready", s_axis_tready, 64'd0);
    chk("rst_pkt_cnt", pkt_cnt, 64'd0);
    chk("rst_match_cnt", match_cnt, 64'd0);
    chk("rst_match_pulse", match_pulse, 64'd0);
    tick();
    ARESETN = 1'b1;
    tick();
    @(negedge ACLK);
    chk("post_rst_s_tready", s_axis_tready, 64'd1);
    tick();

    // Directed packet table, output always ready.
    for (int i = 0; i < 9; i++) begin
      ctrl_en_scn = tv[i].en;
      for (int b = 0; b < int'(tv[i].nb); b++)
        send(tv[i].d[b], tv[i].k[b], (b == int'(tv[i].nb) - 1), 1'b0);
      chk_cnt($sformatf("vec%0d", i), tv[i].e_pkt, tv[i].e_match, tv[i].e_pul);
    end

    // Clear, then enable dropped mid-packet: scan decision sticks for the whole packet.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk_cnt("clr", 0, 0, 5);
    ctrl_en_scn = 1'b1;
    send(64'h1, 8'hFF, 1'b0, 1'b0);
    ctrl_en_scn = 1'b0;
    send(64'h2, 8'hFF, 1'b0, 1'b0);
    send(64'h00000000_DEADBEEF, 8'hFF, 1'b0, 1'b0);
    send(64'h4, 8'hFF, 1'b1, 1'b0);
    send(64'h00000000_DEADBEEF, 8'hFF, 1'b1, 1'b0);
    chk_cnt("en_drop", 1, 1, 6);

    // Back-to-back single-beat bypass packets with random output backpressure.
    lat_chk = 1'b0;
    occ_chk = 1'b1;
    rand_rdy = 1'b1;
    for (int i = 0; i < 24; i++) send({$urandom, $urandom}, 8'hFF, 1'b1, 1'b0);
    drain();
    rand_rdy = 1'b0;
    occ_chk = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    lat_chk = 1'b1;
    chk_cnt("rand_bypass", 1, 1, 6);

    // Clear coincident with a matching last beat.
    ctrl_en_scn = 1'b1;
    send(64'h00000000_DEADBEEF, 8'hFF, 1'b1, 1'b0);
    chk_cnt("pre_clr", 2, 2, 7);
    send(64'h00000000_DEADBEEF, 8'hFF, 1'b1, 1'b1);
    chk_cnt("clr_vs_inc", 0, 0, 8);
    send(64'h00000000_DEADBEEF, 8'hFF, 1'b1, 1'b0);
    chk_cnt("pre_reset", 1, 1, 9);

    // Reset mid-packet with both slice entries occupied.
    lat_chk = 1'b0;
    m_axis_tready = 1'b0;
    send(64'hA, 8'hFF, 1'b0, 1'b0);
    send(64'hB, 8'hFF, 1'b0, 1'b0);
    ARESETN = 1'b0;
    exp_q.delete();
    tick();
    @(negedge ACLK);
    chk("midrst_m_tvalid", m_axis_tvalid, 64'd0);
    chk("midrst_s_tready", s_axis_tready, 64'd0);
    chk("midrst_pkt_cnt", pkt_cnt, 64'd0);
    chk("midrst_match_cnt", match_cnt, 64'd0);
    tick();
    ARESETN = 1'b1;
    m_axis_tready = 1'b1;
    tick();
    @(negedge ACLK);
    chk("midrst_s_tready_up", s_axis_tready, 64'd1);
    tick();
    lat_chk = 1'b1;
    // A fresh start samples enable=0, so this matching beat is bypassed.
    ctrl_en_scn = 1'b0;
    send(64'h00000000_DEADBEEF, 8'hFF, 1'b1, 1'b0);
    chk_cnt("after_rst_bypass", 0, 0, 9);
    ctrl_en_scn = 1'b1;
    send(64'hDEADBEEF_00000000, 8'hFF, 1'b1, 1'b0);
    chk_cnt("after_rst_scan", 1, 1, 10);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
